// File: rtl/quad_decoder_multi.sv
// rtl/quad_decoder_multi.sv - multi-channel quadrature decoder with glitch filters, error/idle tracking and snapshot.
// Optional index-pulse zeroing is enabled by defining QDEC_INDEX_EN.
module quad_decoder_multi #(
    parameter int NCH      = 2,
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4,
    parameter int IDLE_CYC = 5_000_000,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         enc_a,
    input  logic [NCH-1:0]         enc_b,
    input  logic [NCH-1:0]         enc_z,
    input  logic [NCH-1:0]         clr,
    input  logic                   cap_req,
    output logic [2*NCH-1:0]       dir,
    output logic [NCH*CNT_W-1:0]   position,
    output logic [NCH*CNT_W-1:0]   pos_cap,
    output logic                   cap_valid,
    output logic [NCH*ERR_W-1:0]   err_cnt
);

`ifdef QDEC_INDEX_EN
    localparam int NIN = 3;
`else
    localparam int NIN = 2;
    logic unused_z;
    assign unused_z = ^enc_z;
`endif

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC - 1);

    logic [NCH*CNT_W-1:0] pos_nxt;
    logic [NCH*CNT_W-1:0] pos_cap_q;
    logic                 cap_valid_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [NIN-1:0] raw;
        logic [NIN-1:0] filt;

        assign raw[0] = enc_a[i];
        assign raw[1] = enc_b[i];
`ifdef QDEC_INDEX_EN
        assign raw[2] = enc_z[i];
`endif

        // Filtered level flips only on the FILT_LEN-th consecutive differing sample.
        for (genvar j = 0; j < NIN; j++) begin : g_in
            logic          s1_q;
            logic          s2_q;
            logic          flt_q;
            logic [FW-1:0] fcnt_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    flt_q  <= 1'b0;
                    fcnt_q <= '0;
                end else begin
                    s1_q <= raw[j];
                    s2_q <= s1_q;
                    if (s2_q != flt_q) begin
                        if (fcnt_q == FILT_MAX) begin
                            flt_q  <= s2_q;
                            fcnt_q <= '0;
                        end else begin
                            fcnt_q <= fcnt_q + 1'b1;
                        end
                    end else begin
                        fcnt_q <= '0;
                    end
                end
            end

            assign filt[j] = flt_q;
        end

        logic [1:0]       ab_prev_q;
        logic [1:0]       idx_cur;
        logic [1:0]       idx_prev;
        logic             step_cw;
        logic             step_ccw;
        logic             step_err;
        logic             z_rise;
        logic [CNT_W-1:0] pos_q;
        logic [CNT_W-1:0] pos_d;
        logic [ERR_W-1:0] err_q;
        logic [ERR_W-1:0] err_d;
        logic [1:0]       dir_q;
        logic [IW-1:0]    idle_q;
        logic [IW-1:0]    idle_nxt;

        // Map {A,B} = 00,10,11,01 onto phase 0..3 so CW is +1 and CCW is -1 mod 4.
        assign idx_cur  = {filt[1], filt[0] ^ filt[1]};
        assign idx_prev = {ab_prev_q[1], ab_prev_q[0] ^ ab_prev_q[1]};
        assign step_cw  = (idx_cur == idx_prev + 2'd1);
        assign step_ccw = (idx_cur == idx_prev - 2'd1);
        assign step_err = ((filt[1:0] ^ ab_prev_q) == 2'b11);

`ifdef QDEC_INDEX_EN
        logic z_prev_q;
        assign z_rise = filt[2] & ~z_prev_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                z_prev_q <= 1'b0;
            end else begin
                z_prev_q <= filt[2];
            end
        end
`else
        assign z_rise = 1'b0;
`endif

        // Saturates at IDLE_CYC-1, i.e. the IDLE_CYC-th cycle counting the step cycle itself.
        assign idle_nxt = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);

        always_comb begin
            pos_d = pos_q;
            err_d = err_q;
            if (step_cw) begin
                pos_d = pos_q + CNT_W'(1);
            end else if (step_ccw) begin
                pos_d = pos_q - CNT_W'(1);
            end
            if (z_rise) begin
                pos_d = '0;
            end
            if (step_err && (err_q != {ERR_W{1'b1}})) begin
                err_d = err_q + ERR_W'(1);
            end
            if (clr[i]) begin
                pos_d = '0;
                err_d = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ab_prev_q <= 2'b00;
                pos_q     <= '0;
                err_q     <= '0;
                dir_q     <= 2'b00;
                idle_q    <= '0;
            end else begin
                ab_prev_q <= filt[1:0];
                pos_q     <= pos_d;
                err_q     <= err_d;
                if (step_cw || step_ccw || step_err) begin
                    idle_q <= '0;
                end else begin
                    idle_q <= idle_nxt;
                end
                if (step_cw) begin
                    dir_q <= 2'b01;
                end else if (step_ccw) begin
                    dir_q <= 2'b11;
                end else if (step_err) begin
                    dir_q <= 2'b10;
                end else if (idle_nxt == IDLE_MAX) begin
                    dir_q <= 2'b00;
                end
            end
        end

        assign pos_nxt[i*CNT_W +: CNT_W]  = pos_d;
        assign position[i*CNT_W +: CNT_W] = pos_q;
        assign err_cnt[i*ERR_W +: ERR_W]  = err_q;
        assign dir[2*i +: 2]              = dir_q;
    end

    // Snapshot takes next-state positions so it matches what position shows in the strobe cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_cap_q   <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_valid_q <= cap_req;
            if (cap_req) begin
                pos_cap_q <= pos_nxt;
            end
        end
    end

    assign pos_cap   = pos_cap_q;
    assign cap_valid = cap_valid_q;

endmodule

// File: tb/tb_quad_decoder_multi.sv
// tb/tb_quad_decoder_multi.sv - directed self-checking bench for quad_decoder_multi.
module tb_quad_decoder_multi;
    localparam int NCH      = 2;
    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 4;
    localparam int IDLE_CYC = 100;
    localparam int ERR_W    = 8;

    logic                 clk;
    logic                 reset;
    logic [NCH-1:0]       enc_a;
    logic [NCH-1:0]       enc_b;
    logic [NCH-1:0]       enc_z;
    logic [NCH-1:0]       clr;
    logic                 cap_req;
    logic [2*NCH-1:0]     dir;
    logic [NCH*CNT_W-1:0] position;
    logic [NCH*CNT_W-1:0] pos_cap;
    logic                 cap_valid;
    logic [NCH*ERR_W-1:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int idx [NCH];

    quad_decoder_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .IDLE_CYC(IDLE_CYC), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .clr(clr),
        .cap_req(cap_req), .dir(dir), .position(position), .pos_cap(pos_cap),
        .cap_valid(cap_valid), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Phase 0..3 maps to {A,B} = 00,10,11,01.
    task automatic drive(input int ch, input int v);
        idx[ch]   = v & 3;
        enc_a[ch] = (idx[ch] == 1) || (idx[ch] == 2);
        enc_b[ch] = (idx[ch] >= 2);
    endtask

    task automatic step(input int ch, input bit cw);
        drive(ch, cw ? idx[ch] + 1 : idx[ch] + 3);
    endtask

    function automatic logic [CNT_W-1:0] pos(input int ch);
        return position[ch*CNT_W +: CNT_W];
    endfunction

    function automatic logic [ERR_W-1:0] err(input int ch);
        return err_cnt[ch*ERR_W +: ERR_W];
    endfunction

    function automatic logic [1:0] dr(input int ch);
        return dir[2*ch +: 2];
    endfunction

    initial begin
        reset   = 1'b0;
        enc_a   = '0;
        enc_b   = '0;
        enc_z   = '0;
        clr     = '0;
        cap_req = 1'b0;
        idx[0]  = 0;
        idx[1]  = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_position", 32'(position), 32'h0);
        chk("rst_pos_cap", 32'(pos_cap), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_cap_valid", 32'(cap_valid), 32'h0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // Latency of the first CW edge, then the remaining 31 edges at 50 clk each.
        step(0, 1'b1);
        tick(6);
        chk("lat_before", 32'(pos(0)), 32'h0);
        tick(1);
        chk("lat_at7", 32'(pos(0)), 32'h1);
        chk("lat_dir", 32'(dr(0)), 32'h1);
        tick(43);
        for (int k = 0; k < 31; k++) begin
            step(0, 1'b1);
            tick(50);
        end
        chk("cw32_pos", 32'(pos(0)), 32'd32);
        chk("cw32_dir", 32'(dr(0)), 32'h1);
        chk("cw32_err", 32'(err(0)), 32'h0);

        // Idle timeout: dir stays CW for 99 cycles after the step, then goes idle.
        step(0, 1'b1);
        tick(7);
        chk("idle_step_pos", 32'(pos(0)), 32'd33);
        tick(98);
        chk("idle_dir_99", 32'(dr(0)), 32'h1);
        tick(1);
        chk("idle_dir_100", 32'(dr(0)), 32'h0);

        // Ch1 glitches: 3-cycle pulse rejected, 4-cycle pulse accepted and undone.
        enc_a[1] = 1'b1;
        tick(3);
        enc_a[1] = 1'b0;
        tick(20);
        chk("glitch3_pos", 32'(pos(1)), 32'h0);
        chk("glitch3_dir", 32'(dr(1)), 32'h0);
        chk("glitch3_err", 32'(err(1)), 32'h0);
        enc_a[1] = 1'b1;
        tick(4);
        enc_a[1] = 1'b0;
        tick(3);
        chk("glitch4_up", 32'(pos(1)), 32'h1);
        tick(4);
        chk("glitch4_back", 32'(pos(1)), 32'h0);
        chk("glitch4_dir", 32'(dr(1)), 32'h3);

        // Errors on ch0 from phase 00.
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1);
            tick(10);
        end
        chk("pre_err_pos", 32'(pos(0)), 32'd36);
        for (int k = 0; k < 3; k++) begin
            drive(0, idx[0] ^ 2);
            tick(10);
        end
        chk("err3_cnt", 32'(err(0)), 32'd3);
        chk("err3_dir", 32'(dr(0)), 32'h2);
        chk("err3_pos", 32'(pos(0)), 32'd36);
        for (int k = 0; k < 297; k++) begin
            drive(0, idx[0] ^ 2);
            tick(8);
        end
        tick(10);
        chk("err300_sat", 32'(err(0)), 32'd255);
        chk("err300_pos", 32'(pos(0)), 32'd36);

        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr_pos", 32'(pos(0)), 32'h0);
        chk("clr_err", 32'(err(0)), 32'h0);
        chk("clr_dir", 32'(dr(0)), 32'h2);

        // Wrap in both directions at CNT_W=8.
        for (int k = 0; k < 127; k++) begin
            step(0, 1'b1);
            tick(8);
        end
        chk("wrap_127", 32'(pos(0)), 32'h7F);
        step(0, 1'b1);
        tick(8);
        chk("wrap_up", 32'(pos(0)), 32'h80);
        step(0, 1'b0);
        tick(8);
        chk("wrap_down", 32'(pos(0)), 32'h7F);

        // clr coincident with a step completing.
        step(0, 1'b1);
        tick(6);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr_vs_step", 32'(pos(0)), 32'h0);
        tick(2);
        chk("clr_vs_step_hold", 32'(pos(0)), 32'h0);

        // Capture with ch0 at 5 stepping CW, ch1 at -2.
        for (int k = 0; k < 5; k++) begin
            step(0, 1'b1);
            tick(8);
        end
        for (int k = 0; k < 2; k++) begin
            step(1, 1'b0);
            tick(8);
        end
        chk("cap_pre_pos1", 32'(pos(1)), 32'hFE);
        step(0, 1'b1);
        tick(6);
        chk("cap_valid_idle", 32'(cap_valid), 32'h0);
        cap_req = 1'b1;
        tick(1);
        cap_req = 1'b0;
        chk("cap_data", 32'(pos_cap), 32'hFE06);
        chk("cap_valid_1", 32'(cap_valid), 32'h1);
        tick(1);
        chk("cap_valid_0", 32'(cap_valid), 32'h0);
        chk("cap_data_hold", 32'(pos_cap), 32'hFE06);

        // Simultaneous steps on both channels, with cap_req held.
        step(0, 1'b1);
        step(1, 1'b1);
        cap_req = 1'b1;
        tick(6);
        chk("cap_held_a", 32'(cap_valid), 32'h1);
        tick(1);
        chk("sim_pos", 32'(position), 32'hFF07);
        chk("cap_held_b", 32'(cap_valid), 32'h1);
        chk("cap_held_data", 32'(pos_cap), 32'hFF07);
        cap_req = 1'b0;
        tick(1);
        chk("cap_held_off", 32'(cap_valid), 32'h0);

        // Reset mid-step, then release with ch0 at 00 and ch1 at 11.
        step(0, 1'b1);
        tick(3);
        reset = 1'b1;
        #1;
        chk("arst_pos", 32'(position), 32'h0);
        chk("arst_cap", 32'(pos_cap), 32'h0);
        chk("arst_dir", 32'(dir), 32'h0);
        drive(0, 0);
        drive(1, 2);
        tick(2);
        reset = 1'b0;
        tick(15);
        chk("post_rst_pos", 32'(position), 32'h0);
        chk("post_rst_err0", 32'(err(0)), 32'h0);
        chk("post_rst_err1", 32'(err(1)), 32'h1);
        chk("post_rst_dir1", 32'(dr(1)), 32'h2);

        // Index pulse at position 40.
        for (int k = 0; k < 40; k++) begin
            step(0, 1'b1);
            tick(8);
        end
        chk("idx_pre", 32'(pos(0)), 32'd40);
        enc_z[0] = 1'b1;
        tick(10);
        enc_z[0] = 1'b0;
        tick(10);
`ifdef QDEC_INDEX_EN
        chk("idx_zero", 32'(pos(0)), 32'h0);
`else
        chk("idx_ignored", 32'(pos(0)), 32'd40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
